// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - word offsets of the register window (d_addr[3:2])
//   - bit positions inside the STATUS register
//   - transmitter FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  // Register word offsets within the 16-byte window.
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;

  // STATUS register bit positions.
  localparam int STATUS_FULL     = 0;
  localparam int STATUS_EMPTY    = 1;
  localparam int STATUS_BUSY     = 2;
  localparam int STATUS_OVERFLOW = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a combinational head output.
// Pointers carry one extra wrap bit so full/empty fall out of an MSB compare.
// A push while full is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write request
//   data_i   in   write data
//   pop_i    in   read request (ignored when empty)
//   head_o   out  oldest entry, valid when empty_o is low
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the write side is a lap ahead.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter. Decodes a 16-byte window on the core
// data port, queues TXDATA writes in a FIFO and serialises them on tx.
//
// Register map (word offset d_addr[3:2]):
//   0 TXDATA  W: push d_wr_data[7:0]      R: STATUS value
//   1 STATUS  R: {overflow,busy,empty,full}  W: bit3=1 clears overflow
//   2 BAUDDIV R/W: clocks per bit, 16 bits (0 is stored as 1)
//   3 reserved (reads 0, writes ignored)
//
// Ports:
//   clk        in   core clock
//   rst        in   synchronous active-high reset
//   d_addr     in   byte address from core data port
//   d_we       in   write enable/size; any nonzero value is a write
//   d_wr_data  in   write data
//   d_rd_data  out  registered read data, valid one cycle after address
//   hit        out  registered window match, selects this block on the bus
//   tx         out  serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_we,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        hit,
  output logic        tx
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       in_window;
  logic [1:0] offset;
  logic       is_write;
  logic       push;
  logic       pop;
  logic       overflow_event;
  logic       ovf_clear;
  logic       baud_write;

  assign in_window  = (d_addr[31:4] == BASE_ADDR[31:4]);
  assign offset     = d_addr[3:2];
  assign is_write   = in_window && (d_we != 2'b00);
  assign push       = is_write && (offset == UART_TXDATA);
  assign ovf_clear  = is_write && (offset == UART_STATUS) &&
                      d_wr_data[STATUS_OVERFLOW];
  assign baud_write = is_write && (offset == UART_BAUDDIV);

  logic unused_bits;
  assign unused_bits = ^{d_addr[1:0], d_wr_data[31:16]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (d_wr_data[7:0]),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Transmitter state
  // ---------------------------------------------------------------------------
  uart_state_t state_q;
  logic [15:0] div_q;       // divisor latched at frame start
  logic [15:0] cnt_q;       // cycles elapsed in the current bit
  logic [2:0]  bit_cnt_q;   // data bits already shifted out
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        bit_end;

  assign bit_end = (cnt_q == (div_q - 16'd1));

  // The FSM only dequeues in IDLE, so a same-cycle full push is accepted then.
  assign pop            = (state_q == IDLE) && !fifo_empty;
  assign overflow_event = push && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // Software-visible registers
  // ---------------------------------------------------------------------------
  logic        overflow_q;
  logic [15:0] baud_q;
  logic [31:0] rd_data_q;
  logic        hit_q;
  logic [31:0] status;
  logic [31:0] rd_data_d;

  always_comb begin
    status                  = 32'd0;
    status[STATUS_FULL]     = fifo_full;
    status[STATUS_EMPTY]    = fifo_empty;
    status[STATUS_BUSY]     = (state_q != IDLE);
    status[STATUS_OVERFLOW] = overflow_q;
  end

  always_comb begin
    rd_data_d = 32'd0;
    if (in_window) begin
      case (offset)
        UART_TXDATA:  rd_data_d = status;
        UART_STATUS:  rd_data_d = status;
        UART_BAUDDIV: rd_data_d = {16'd0, baud_q};
        default:      rd_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= 32'd0;
      hit_q      <= 1'b0;
      overflow_q <= 1'b0;
      baud_q     <= DEFAULT_DIV;
    end else begin
      rd_data_q <= rd_data_d;
      hit_q     <= in_window;
      // A new overflow in the same cycle as a clear keeps the flag set.
      if (overflow_event) begin
        overflow_q <= 1'b1;
      end else if (ovf_clear) begin
        overflow_q <= 1'b0;
      end
      if (baud_write) begin
        baud_q <= (d_wr_data[15:0] == 16'd0) ? 16'd1 : d_wr_data[15:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM. tx is registered from the current state, so the line
  // follows the state by one cycle; every bit still lasts exactly div cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= DEFAULT_DIV;
      cnt_q     <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q   <= fifo_head;
            div_q     <= baud_q;
            cnt_q     <= 16'd0;
            bit_cnt_q <= 3'd0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= 16'd0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q     <= 16'd0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= 16'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_rd_data = rd_data_q;
  assign hit       = hit_q;
  assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_mmio
// Directed self-checking bench for uart_tx_mmio. The tx line is recorded on
// every falling edge into a log, and frames are decoded from that log with
// bench-computed expected bit patterns.
// -----------------------------------------------------------------------------
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr;
  logic [1:0]  d_we;
  logic [31:0] d_wr_data;
  logic [31:0] d_rd_data;
  logic        hit;
  logic        tx;

  int checks = 0;
  int passes = 0;

  logic txlog[$];
  logic log_en = 1'b0;

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_addr    (d_addr),
    .d_we      (d_we),
    .d_wr_data (d_wr_data),
    .d_rd_data (d_rd_data),
    .hit       (hit),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (log_en) txlog.push_back(tx);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] data, input logic [1:0] we);
    @(negedge clk);
    d_addr    = a;
    d_we      = we;
    d_wr_data = data;
    @(posedge clk);
    #1;
    d_we   = 2'b00;
    d_addr = 32'h0;
    $display("write addr=%h data=%h we=%b", a, data, we);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic h);
    @(negedge clk);
    d_addr = a;
    d_we   = 2'b00;
    @(posedge clk);
    #1;
    rd     = d_rd_data;
    h      = hit;
    d_addr = 32'h0;
    $display("read  addr=%h data=%h hit=%b", a, rd, h);
  endtask

  function automatic int find_start();
    for (int i = 0; i < txlog.size(); i++) begin
      if (txlog[i] === 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic int count_zeros(input int from);
    int n = 0;
    for (int i = (from < 0 ? 0 : from); i < txlog.size(); i++) begin
      if (txlog[i] !== 1'b1) n++;
    end
    return n;
  endfunction

  // Compare one 8N1 frame starting at log index s; a bit not held for the
  // full div samples (or outside the log) shows as x.
  task automatic check_frame(input string tag, input int s, input logic [7:0] b, input int div);
    logic [9:0] exp_bits;
    logic [9:0] obs_bits;
    exp_bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (s < 0 || s + (k + 1) * div > txlog.size()) begin
        obs_bits[k] = 1'bx;
      end else begin
        obs_bits[k] = txlog[s + k * div];
        for (int j = 1; j < div; j++) begin
          if (txlog[s + k * div + j] !== obs_bits[k]) obs_bits[k] = 1'bx;
        end
      end
    end
    $display("frame %s start=%0d byte=%h div=%0d bits=%b", tag, s, b, div, obs_bits);
    check(tag, {22'd0, obs_bits}, {22'd0, exp_bits});
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    logic [9:0]  frame;
    int          s0;
    logic [31:0] exp_tx;
    logic [31:0] exp_st;

    rst       = 1'b1;
    d_addr    = 32'h0;
    d_we      = 2'b00;
    d_wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data", d_rd_data, 32'h0);
    check("reset_hit", {31'd0, hit}, 32'd1 - 32'd1);
    check("reset_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // ---- Reset state through the register window ----
    bus_read(BASE + 32'h4, rd, h);
    check("status_after_reset", rd, 32'h2);
    check("status_hit", {31'd0, h}, 32'd1);
    check("tx_idle", {31'd0, tx}, 32'd1);
    bus_read(BASE + 32'h8, rd, h);
    check("bauddiv_reset", rd, 32'd868);

    // ---- div=4, single byte 0x55, cycle-exact tx and busy ----
    bus_write(BASE + 32'h8, 32'd4, 2'b11);
    bus_write(BASE + 32'h0, 32'h55, 2'b01);
    d_addr = BASE + 32'h4;
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 1; i <= 42; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 || i == 42) exp_tx = 32'd1;
      else                   exp_tx = {31'd0, frame[(i - 2) / 4]};
      if (i == 1)       exp_st = 32'h0;
      else if (i == 42) exp_st = 32'h2;
      else              exp_st = 32'h6;
      $display("cycle %0d tx=%b status=%h", i, tx, d_rd_data);
      check($sformatf("tx_0x55_c%0d", i), {31'd0, tx}, exp_tx);
      check($sformatf("status_0x55_c%0d", i), d_rd_data, exp_st);
    end
    d_addr = 32'h0;

    // ---- div=2, fill the FIFO, then overflow ----
    bus_write(BASE + 32'h8, 32'd2, 2'b10);
    txlog.delete();
    log_en = 1'b1;
    for (int k = 0; k < 9; k++) bus_write(BASE + 32'h0, k, 2'b01);
    bus_read(BASE + 32'h4, rd, h);
    check("status_full_no_ovf", rd, 32'h5);
    bus_write(BASE + 32'h0, 32'hEE, 2'b01);
    bus_read(BASE + 32'h4, rd, h);
    check("status_overflow", rd, 32'hD);
    rd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      bus_read(BASE + 32'h4, rd, h);
      if (rd == 32'hA) break;
    end
    check("status_drained", rd, 32'hA);
    log_en = 1'b0;
    s0 = find_start();
    for (int k = 0; k < 9; k++) begin
      check_frame($sformatf("burst_byte%0d", k), s0 + k * 21, k[7:0], 2);
    end
    check("no_dropped_byte_sent", count_zeros(s0 + 9 * 21), 32'd0);

    // ---- overflow clear, BAUDDIV=0 stored as 1 ----
    bus_write(BASE + 32'h4, 32'h8, 2'b11);
    bus_read(BASE + 32'h4, rd, h);
    check("overflow_cleared", rd, 32'h2);
    bus_write(BASE + 32'h8, 32'h0, 2'b11);
    bus_read(BASE + 32'h8, rd, h);
    check("bauddiv_zero_as_one", rd, 32'd1);
    txlog.delete();
    log_en = 1'b1;
    bus_write(BASE + 32'h0, 32'hA5, 2'b01);
    repeat (20) @(posedge clk);
    log_en = 1'b0;
    check_frame("div1_0xA5", find_start(), 8'hA5, 1);

    // ---- BAUDDIV change mid-frame applies to the next frame ----
    bus_write(BASE + 32'h8, 32'd4, 2'b11);
    txlog.delete();
    log_en = 1'b1;
    bus_write(BASE + 32'h0, 32'h3C, 2'b01);
    repeat (5) @(posedge clk);
    bus_write(BASE + 32'h8, 32'd8, 2'b11);
    bus_write(BASE + 32'h0, 32'hC3, 2'b01);
    repeat (150) @(posedge clk);
    log_en = 1'b0;
    s0 = find_start();
    check_frame("midframe_old_div", s0, 8'h3C, 4);
    check_frame("midframe_new_div", s0 + 41, 8'hC3, 8);
    bus_read(BASE + 32'h8, rd, h);
    check("bauddiv_8", rd, 32'd8);

    // ---- reset during DATA with bytes queued ----
    for (int k = 0; k < 4; k++) bus_write(BASE + 32'h0, 32'h0, 2'b01);
    repeat (20) @(posedge clk);
    #1;
    check("tx_low_in_data", {31'd0, tx}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("tx_high_after_reset", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    txlog.delete();
    log_en = 1'b1;
    bus_read(BASE + 32'h4, rd, h);
    check("status_after_midframe_reset", rd, 32'h2);
    repeat (100) @(posedge clk);
    log_en = 1'b0;
    check("no_frames_after_reset", count_zeros(0), 32'd0);
    bus_read(BASE + 32'h8, rd, h);
    check("bauddiv_after_reset", rd, 32'd868);

    // ---- out-of-window and reserved accesses ----
    bus_read(BASE + 32'h10, rd, h);
    check("outside_rd_data", rd, 32'h0);
    check("outside_hit", {31'd0, h}, 32'd0);
    bus_write(BASE + 32'h10, 32'h00, 2'b01);
    bus_read(BASE + 32'h4, rd, h);
    check("outside_write_no_push", rd, 32'h2);
    bus_write(BASE + 32'h18, 32'd5, 2'b11);
    bus_read(BASE + 32'hC, rd, h);
    check("reserved_read", rd, 32'h0);
    check("reserved_hit", {31'd0, h}, 32'd1);
    bus_write(BASE + 32'hC, 32'd5, 2'b11);
    bus_read(BASE + 32'h8, rd, h);
    check("bauddiv_unchanged", rd, 32'd868);
    bus_read(BASE + 32'h0, rd, h);
    check("txdata_reads_status", rd, 32'h2);
    bus_read(BASE + 32'h5, rd, h);
    check("low_addr_bits_ignored", rd, 32'h2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the core data port, downstream of the core's load/store unit. It decodes its own address window and buffers written bytes in a small FIFO. It serialises each byte as 8N1 on a single tx line. A status register gives software a polling interface. The top-level data-bus mux selects d_rd_data from this block when hit is asserted.

Parameters:
BASE_ADDR, 32'h8000_0000, base of the 16-byte register window; must be 16-byte aligned
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clocks per bit

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
d_addr  input  32  byte address from core data port
d_we  input  2  write enable/size from core; any nonzero value is a write
d_wr_data  input  32  write data; only [7:0] is used for TXDATA, [15:0] for BAUDDIV
d_rd_data  output  32  registered read data, valid one cycle after address
hit  output  1  registered; d_addr was in window last cycle; drives the bus mux select
tx  output  1  serial output, idle high

Behaviour:
- Window: d_addr[31:4] == BASE_ADDR[31:4]. Word offsets are d_addr[3:2]: 0=TXDATA, 1=STATUS, 2=BAUDDIV, 3=reserved.
- Reads from reserved offsets return 0. Writes to reserved offsets are ignored. d_addr[1:0] is ignored.
- Read latency is 1 cycle. On every edge, d_rd_data takes the selected register and hit takes the window match.
- When not in the window, d_rd_data is 0. Reads have no side effects.
- STATUS bits: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky). All other bits are 0.
- TXDATA reads return the STATUS value.
- A TXDATA write pushes d_wr_data[7:0].
- If the FIFO is full and no pop occurs in the same cycle, the push is dropped and overflow is set.
- If a push and a pop occur in the same cycle while full, the push is accepted.
- Writing STATUS with bit3=1 clears overflow. If an overflow event occurs in the same cycle, set wins.
- BAUDDIV is a 16-bit register. A written value of 0 is stored as 1.
- The divisor is latched when a frame starts, so BAUDDIV writes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into a shift register, latch the divisor, load the bit counter=0, and go to START.
  - START: tx=0 for div cycles, then go to DATA.
  - DATA: tx=shift[0], LSB first. Shift every div cycles; after 8 bits go to STOP.
  - STOP: tx=1 for div cycles, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames.
- tx is registered. Timing for a TXDATA write accepted at edge N with the FIFO empty and the FSM idle:
  - FIFO non-empty after edge N.
  - Pop at edge N+1.
  - tx falls after edge N+2.
  - Frame length is 10*div cycles.
- Reset values: tx=1, d_rd_data=0, hit=0, FIFO empty, overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE.
- Reset mid-frame aborts the frame: tx returns high after the reset edge and queued data is discarded.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full/empty come from MSB comparison.

Decomposition:
- Package uart_pkg holds:
  - register offset constants (UART_TXDATA=2'd0, UART_STATUS=2'd1, UART_BAUDDIV=2'd2)
  - STATUS bit index constants
  - the uart_state_t enum {IDLE, START, DATA, STOP}
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty, registered storage, combinational head.
- uart_tx_mmio contains the address decode, registers, baud counter and FSM.

Test Plan:
- Reset, then read STATUS at BASE+4 -> next-cycle d_rd_data=32'h2 and hit=1; tx=1; BAUDDIV read returns 868.
- Write BAUDDIV=4, write TXDATA=0x55 -> tx falls 2 cycles after the write edge. tx then shows the pattern 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles. busy=1 throughout, then STATUS=32'h2.
- With div=2, write 9 bytes 0x00..0x08 back-to-back -> first is popped immediately and 8 fill the FIFO, so no overflow. A 10th write sets STATUS bit3. Transmitted bytes are 0x00..0x08 in order, each separated by exactly 1 idle cycle.
- Write STATUS=0x8 while overflow is set -> overflow clears. Write BAUDDIV=0 -> reads back 1, and the next frame uses a 1-cycle bit period.
- Write BAUDDIV=8 mid-frame while div=4 -> the current frame stays at 4 cycles/bit and the next frame uses 8.
- Assert rst during the DATA state with 3 bytes queued -> after the reset edge tx=1, STATUS=32'h2, and no further frames are sent.
- Access to BASE+0x10 -> hit=0 and d_rd_data=0 with no state change. A read at BASE+0xC returns 0.
